// File: rtl/pwr_dvfs_sequencer_if.sv
// Request, regulator, PLL and status signals between the DVFS sequencer and its neighbours.
// The sequencer takes the slave view; the requester/regulator/PLL side takes the master view.
interface pwr_dvfs_sequencer_if;
   logic       req_valid;
   logic [1:0] req_mode;
   logic       req_ready;
   logic       vreg_req;
   logic [1:0] vreg_level;
   logic       vreg_ack;
   logic       pll_req;
   logic [1:0] pll_sel;
   logic       pll_lock;
   logic [1:0] performance_mode;
   logic       busy;
   logic       err_timeout;
   logic       err_sticky;
   logic       err_clr;

   modport slave (
      input  req_valid, req_mode, vreg_ack, pll_lock, err_clr,
      output req_ready, vreg_req, vreg_level, pll_req, pll_sel,
             performance_mode, busy, err_timeout, err_sticky
   );

   modport master (
      output req_valid, req_mode, vreg_ack, pll_lock, err_clr,
      input  req_ready, vreg_req, vreg_level, pll_req, pll_sel,
             performance_mode, busy, err_timeout, err_sticky
   );
endinterface

// File: rtl/pwr_dvfs_sequencer.sv
// DVFS sequencer: raises voltage before frequency going up, lowers frequency before voltage
// going down, and commits performance_mode only after the PLL has locked and settled.
module pwr_dvfs_sequencer #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input logic                clk,
   input logic                rst_n,
   pwr_dvfs_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      V_UP   = 3'd1,
      F_CHG  = 3'd2,
      SETTLE = 3'd3,
      V_DOWN = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       tgt_q, tgt_d;
   logic             pend_q, pend_d;
   logic             dir_up_q, dir_up_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       vlevel_q, vlevel_d;
   logic [1:0]       psel_q, psel_d;
   logic             err_to_q, err_to_d;
   logic             err_st_q, err_st_d;
   logic             abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tgt_q    <= 2'b00;
         pend_q   <= 1'b0;
         dir_up_q <= 1'b0;
         mode_q   <= 2'b00;
         vlevel_q <= 2'b00;
         psel_q   <= 2'b00;
         err_to_q <= 1'b0;
         err_st_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tgt_q    <= tgt_d;
         pend_q   <= pend_d;
         dir_up_q <= dir_up_d;
         mode_q   <= mode_d;
         vlevel_q <= vlevel_d;
         psel_q   <= psel_d;
         err_to_q <= err_to_d;
         err_st_q <= err_st_d;
      end
   end

   // The accepted target is compared with the committed mode one cycle after the handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      tgt_d    = tgt_q;
      pend_d   = pend_q;
      dir_up_d = dir_up_q;
      mode_d   = mode_q;
      vlevel_d = vlevel_q;
      psel_d   = psel_q;
      abort    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.req_valid) begin
               tgt_d  = bus.req_mode;
               pend_d = 1'b1;
            end else if (pend_q) begin
               pend_d = 1'b0;
               if (tgt_q > mode_q) begin
                  state_d  = V_UP;
                  dir_up_d = 1'b1;
                  vlevel_d = tgt_q;
               end else if (tgt_q < mode_q) begin
                  state_d  = F_CHG;
                  dir_up_d = 1'b0;
                  psel_d   = tgt_q;
               end
            end
         end
         V_UP: begin
            if (bus.vreg_ack) begin
               state_d = F_CHG;
               cnt_d   = '0;
               psel_d  = tgt_q;
            end else if (cnt_q == TO_LAST) begin
               abort = 1'b1;
            end
         end
         F_CHG: begin
            // A lock seen in the first cycle may predate the new pll_sel, so it is not trusted.
            if (bus.pll_lock && (cnt_q != '0)) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               abort = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               mode_d = tgt_q;
               cnt_d  = '0;
               if (dir_up_q) begin
                  state_d = IDLE;
               end else begin
                  state_d  = V_DOWN;
                  vlevel_d = tgt_q;
               end
            end
         end
         V_DOWN: begin
            if (bus.vreg_ack) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               abort = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end

      err_to_d = abort;
      err_st_d = abort ? 1'b1 : (bus.err_clr ? 1'b0 : err_st_q);
   end

   assign bus.req_ready        = (state_q == IDLE);
   assign bus.busy             = (state_q != IDLE);
   assign bus.vreg_req         = (state_q == V_UP) || (state_q == V_DOWN);
   assign bus.pll_req          = (state_q == F_CHG);
   assign bus.vreg_level       = vlevel_q;
   assign bus.pll_sel          = psel_q;
   assign bus.performance_mode = mode_q;
   assign bus.err_timeout      = err_to_q;
   assign bus.err_sticky       = err_st_q;

endmodule
